ppu_vblank_nmi_gen: RTL and testbench

//  PPU-side source of the vertical-blank NMI consumed by the CPU interrupt handler's NMI latch.
//  - Runs the NTSC dot/scanline timebase.
//  - Owns the PPUCTRL ($2000) and PPUMASK ($2001) shadow registers and the PPUSTATUS ($2002) flags.
//  - Raises the NMI request at vblank start and clears the flags at pre-render.
//  - Sits between the PPU register decode and the interrupt handler's ppu_status input.

---
 rtl/ppu_vblank_nmi_gen.sv | 216 +++++++++++++++++++++
 tb/tb_ppu_vblank_nmi_gen.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_vblank_nmi_gen.sv
// ---------------------------------------------------------------------------
// ppu_vblank_nmi_gen
//
// Purpose:
//   PPU-side source of the vertical-blank NMI.
//   - Runs the NTSC dot/scanline timebase.
//   - Holds the PPUCTRL/PPUMASK shadow registers and the PPUSTATUS flags.
//   - Raises a one-clk NMI request at vblank start, or when NMI is enabled
//     while vblank is already set.
//   - Clears the status flags on the pre-render line.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   dot_en          one-clk PPU dot tick; timebase and flag events advance on it
//   reg_addr        PPU register select (CPU addr[2:0])
//   reg_data_in     CPU write data
//   reg_write_en    register write strobe
//   reg_read_en     register read strobe
//   reg_data_out    registered $2002 read data, valid the clk after the read
//   sprite0_set     sets the sprite-0 hit flag
//   sprite_ovf_set  sets the sprite overflow flag
//   ppu_status      {nmi_req, sprite0, ovf, 5'b0} toward the interrupt handler
//   nmi_req         one-clk NMI request pulse
//   ppuctrl         PPUCTRL shadow
//   ppumask         PPUMASK shadow
//   addr_latch_clr  one-clk pulse clearing the $2005/$2006 write toggle
//   scanline, dot   current raster position
//   frame_odd       toggles at every frame wrap
//
// Configuration macro:
//   ODD_FRAME_SKIP_EN - when defined, odd frames with rendering enabled
//                       (ppumask[3] or ppumask[4]) drop the last pre-render
//                       dot. When undefined every frame has the full length.
// ---------------------------------------------------------------------------
module ppu_vblank_nmi_gen #(
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int VBLANK_LINE     = 241,
  parameter int PRERENDER_LINE  = 261
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dot_en,
  input  logic [2:0] reg_addr,
  input  logic [7:0] reg_data_in,
  input  logic       reg_write_en,
  input  logic       reg_read_en,
  output logic [7:0] reg_data_out,
  input  logic       sprite0_set,
  input  logic       sprite_ovf_set,
  output logic [7:0] ppu_status,
  output logic       nmi_req,
  output logic [7:0] ppuctrl,
  output logic [7:0] ppumask,
  output logic       addr_latch_clr,
  output logic [8:0] scanline,
  output logic [8:0] dot,
  output logic       frame_odd
);

  localparam logic [8:0] DOT_LAST  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] LINE_LAST = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] LINE_VBL  = 9'(VBLANK_LINE);
  localparam logic [8:0] LINE_PRE  = 9'(PRERENDER_LINE);

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;

  // Internal flags
  logic vblank;
  logic sprite0;
  logic ovf;

  // Decoded register accesses
  logic status_rd;
  logic ctrl_wr;
  logic mask_wr;

  // Raster events, qualified by dot_en
  logic vbl_evt;
  logic pre_evt;
  logic skip_dot;

  // Next-state values
  logic [8:0] dot_nxt;
  logic [8:0] line_nxt;
  logic       odd_nxt;
  logic       vblank_nxt;
  logic       sprite0_nxt;
  logic       ovf_nxt;
  logic       nmi_nxt;

  assign status_rd = reg_read_en  && (reg_addr == ADDR_STATUS);
  assign ctrl_wr   = reg_write_en && (reg_addr == ADDR_CTRL);
  assign mask_wr   = reg_write_en && (reg_addr == ADDR_MASK);

  assign vbl_evt = dot_en && (scanline == LINE_VBL) && (dot == 9'd1);
  assign pre_evt = dot_en && (scanline == LINE_PRE) && (dot == 9'd1);

  // -------------------------------------------------------------------------
  // Timebase
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    dot_nxt  = dot;
    line_nxt = scanline;
    odd_nxt  = frame_odd;
    skip_dot = 1'b0;
`ifdef ODD_FRAME_SKIP_EN
    // Odd frame with rendering on: the tick at the second-to-last pre-render
    // dot jumps straight to (0,0).
    skip_dot = frame_odd && (ppumask[3] || ppumask[4]) &&
               (scanline == LINE_PRE) && (dot == 9'(DOTS_PER_LINE - 2));
`else
    skip_dot = 1'b0;
`endif
    if (dot_en) begin
      if (skip_dot) begin
        dot_nxt  = 9'd0;
        line_nxt = 9'd0;
        odd_nxt  = ~frame_odd;
      end else if (dot == DOT_LAST) begin
        dot_nxt = 9'd0;
        if (scanline == LINE_LAST) begin
          line_nxt = 9'd0;
          odd_nxt  = ~frame_odd;
        end else begin
          line_nxt = scanline + 9'd1;
        end
      end else begin
        dot_nxt = dot + 9'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Status flags and NMI request
  // -------------------------------------------------------------------------
  always_comb begin
    vblank_nxt  = vblank;
    sprite0_nxt = sprite0;
    ovf_nxt     = ovf;

    if (pre_evt) begin
      // Pre-render clear beats any same-clk sprite flag set.
      vblank_nxt  = 1'b0;
      sprite0_nxt = 1'b0;
      ovf_nxt     = 1'b0;
    end else begin
      // A status read on the vblank-set tick wins: the flag never rises.
      if (status_rd) begin
        vblank_nxt = 1'b0;
      end else if (vbl_evt) begin
        vblank_nxt = 1'b1;
      end
      if (sprite0_set) begin
        sprite0_nxt = 1'b1;
      end
      if (sprite_ovf_set) begin
        ovf_nxt = 1'b1;
      end
    end

    // NMI at vblank start (unless the racing read swallowed it), or when NMI
    // enable rises 0->1 while vblank is already pending. Both sources are
    // single-clk events, so the registered request is always one clk wide.
    nmi_nxt = (vbl_evt && ppuctrl[7] && !status_rd) ||
              (ctrl_wr && !ppuctrl[7] && reg_data_in[7] && vblank);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dot            <= 9'd0;
      scanline       <= 9'd0;
      frame_odd      <= 1'b0;
      vblank         <= 1'b0;
      sprite0        <= 1'b0;
      ovf            <= 1'b0;
      nmi_req        <= 1'b0;
      addr_latch_clr <= 1'b0;
      reg_data_out   <= 8'h00;
      ppuctrl        <= 8'h00;
      ppumask        <= 8'h00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      dot            <= dot_nxt;
      scanline       <= line_nxt;
      frame_odd      <= odd_nxt;
      vblank         <= vblank_nxt;
      sprite0        <= sprite0_nxt;
      ovf            <= ovf_nxt;
      nmi_req        <= nmi_nxt;
      addr_latch_clr <= status_rd;
      if (status_rd) begin
        reg_data_out <= {vblank, sprite0, ovf, 5'b0_0000};
      end
      if (ctrl_wr) begin
        ppuctrl <= reg_data_in;
      end
      if (mask_wr) begin
        ppumask <= reg_data_in;
      end
    end
  end

  // Bit 7 carries the pulse rather than the vblank level so the handler's
  // level-sensitive latch sees one request per event.
  assign ppu_status = {nmi_req, sprite0, ovf, 5'b0_0000};

endmodule

// File: tb/tb_ppu_vblank_nmi_gen.sv
// ---------------------------------------------------------------------------
// tb_ppu_vblank_nmi_gen
//
// Self-checking bench for ppu_vblank_nmi_gen. The DUT runs with a shrunken
// raster (same relative layout) so several full frames fit in a short run.
// A reference model tracks the raster as a linear dot position inside the
// frame and derives scanline/dot by division; flags follow the register
// rules directly. Every output is compared every clk, plus targeted checks
// for reset, NMI timing, the read/set race, flag clearing and frame length.
// ---------------------------------------------------------------------------
module tb_ppu_vblank_nmi_gen;

  localparam int D       = 25;
  localparam int L       = 20;
  localparam int VBL     = 17;
  localparam int PRE     = 19;
  localparam int FRAME   = D * L;
  localparam int VBL_POS = VBL * D + 1;
  localparam int PRE_POS = PRE * D + 1;
  localparam int BUDGET  = 2 * FRAME + 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dot_en = 1'b0;
  logic [2:0] reg_addr = 3'd0;
  logic [7:0] reg_data_in = 8'h00;
  logic       reg_write_en = 1'b0;
  logic       reg_read_en = 1'b0;
  logic       sprite0_set = 1'b0;
  logic       sprite_ovf_set = 1'b0;
  logic [7:0] reg_data_out;
  logic [7:0] ppu_status;
  logic       nmi_req;
  logic [7:0] ppuctrl;
  logic [7:0] ppumask;
  logic       addr_latch_clr;
  logic [8:0] scanline;
  logic [8:0] dot;
  logic       frame_odd;

  ppu_vblank_nmi_gen #(
    .DOTS_PER_LINE  (D),
    .LINES_PER_FRAME(L),
    .VBLANK_LINE    (VBL),
    .PRERENDER_LINE (PRE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dot_en        (dot_en),
    .reg_addr      (reg_addr),
    .reg_data_in   (reg_data_in),
    .reg_write_en  (reg_write_en),
    .reg_read_en   (reg_read_en),
    .reg_data_out  (reg_data_out),
    .sprite0_set   (sprite0_set),
    .sprite_ovf_set(sprite_ovf_set),
    .ppu_status    (ppu_status),
    .nmi_req       (nmi_req),
    .ppuctrl       (ppuctrl),
    .ppumask       (ppumask),
    .addr_latch_clr(addr_latch_clr),
    .scanline      (scanline),
    .dot           (dot),
    .frame_odd     (frame_odd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_pos;
  bit         m_odd, m_vbl, m_s0, m_ovf, m_nmi, m_alc;
  logic [7:0] m_ctrl, m_mask, m_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_odd = 0; m_vbl = 0; m_s0 = 0; m_ovf = 0;
    m_nmi = 0; m_alc = 0; m_ctrl = 8'h00; m_mask = 8'h00; m_rdata = 8'h00;
  endtask

  // One clk of the reference model, using the inputs present at the edge.
  task automatic model_step();
    bit vbl_evt, pre_evt, rd, cw, mw, skip;
    vbl_evt = dot_en && (m_pos == VBL_POS);
    pre_evt = dot_en && (m_pos == PRE_POS);
    rd = reg_read_en && (reg_addr == 3'd2);
    cw = reg_write_en && (reg_addr == 3'd0);
    mw = reg_write_en && (reg_addr == 3'd1);
`ifdef ODD_FRAME_SKIP_EN
    skip = m_odd && (m_mask[3] || m_mask[4]) && (m_pos == FRAME - 2);
`else
    skip = 0;
`endif
    m_nmi = (vbl_evt && m_ctrl[7] && !rd) || (cw && !m_ctrl[7] && reg_data_in[7] && m_vbl);
    m_alc = rd;
    if (rd) m_rdata = {m_vbl, m_s0, m_ovf, 5'b0};
    if (pre_evt) begin
      m_vbl = 0; m_s0 = 0; m_ovf = 0;
    end else begin
      if (rd) m_vbl = 0;
      else if (vbl_evt) m_vbl = 1;
      if (sprite0_set) m_s0 = 1;
      if (sprite_ovf_set) m_ovf = 1;
    end
    if (cw) m_ctrl = reg_data_in;
    if (mw) m_mask = reg_data_in;
    if (dot_en) begin
      if (skip) begin
        m_pos = 0; m_odd = !m_odd;
      end else begin
        m_pos = m_pos + 1;
        if (m_pos == FRAME) begin
          m_pos = 0; m_odd = !m_odd;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("dot", 32'(dot), m_pos % D);
    check("scanline", 32'(scanline), m_pos / D);
    check("frame_odd", 32'(frame_odd), 32'(m_odd));
    check("nmi_req", 32'(nmi_req), 32'(m_nmi));
    check("ppu_status", 32'(ppu_status), 32'({m_nmi, m_s0, m_ovf, 5'b0}));
    check("reg_data_out", 32'(reg_data_out), 32'(m_rdata));
    check("ppuctrl", 32'(ppuctrl), 32'(m_ctrl));
    check("ppumask", 32'(ppumask), 32'(m_mask));
    check("addr_latch_clr", 32'(addr_latch_clr), 32'(m_alc));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dot"}, 32'(dot), 0);
    check({tag, "_scanline"}, 32'(scanline), 0);
    check({tag, "_frame_odd"}, 32'(frame_odd), 0);
    check({tag, "_nmi_req"}, 32'(nmi_req), 0);
    check({tag, "_ppu_status"}, 32'(ppu_status), 0);
    check({tag, "_reg_data_out"}, 32'(reg_data_out), 0);
    check({tag, "_ppuctrl"}, 32'(ppuctrl), 0);
    check({tag, "_ppumask"}, 32'(ppumask), 0);
    check({tag, "_addr_latch_clr"}, 32'(addr_latch_clr), 0);
  endtask

  // Drive one clk of inputs, advance the model at the edge, compare #1 later.
  task automatic step(input logic de, input logic [2:0] a, input logic [7:0] d,
                      input logic we, input logic re, input logic s0s, input logic ovs);
    dot_en = de; reg_addr = a; reg_data_in = d;
    reg_write_en = we; reg_read_en = re;
    sprite0_set = s0s; sprite_ovf_set = ovs;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic de);
    step(de, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    step(1'b0, a, d, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [2:0] a);
    step(1'b0, a, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Tick dot_en until the model reaches the frame position; bounded.
  task automatic run_to(input int target);
    int n;
    n = 0;
    while (m_pos != target && n < BUDGET) begin
      idle(1'b1);
      n++;
    end
    check("run_to_dot", 32'(dot), target % D);
    check("run_to_scanline", 32'(scanline), target / D);
  endtask

  // Count dot ticks until the DUT's frame_odd toggles; bounded.
  task automatic ticks_to_toggle(output int len, output bit odd_during);
    logic start;
    start = frame_odd;
    odd_during = start;
    len = 0;
    while (frame_odd == start && len < FRAME + 8) begin
      idle(1'b1);
      len++;
    end
  endtask

  task automatic frame_lengths(input logic [7:0] mask);
    int len, exp;
    bit odd;
    wr(3'd1, mask);
    ticks_to_toggle(len, odd);   // align to a frame boundary
    for (int f = 0; f < 2; f++) begin
      ticks_to_toggle(len, odd);
      exp = FRAME;
`ifdef ODD_FRAME_SKIP_EN
      if (odd && (mask[3] || mask[4])) exp = FRAME - 1;
`endif
      check($sformatf("frame_len_mask%02h_odd%0d", mask, odd), len, exp);
    end
  endtask

  initial begin
    bit odd_before;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("por");
    @(negedge clk);
    rst = 1'b0;

    // First tick after reset
    idle(1'b1);
    check("first_tick_dot", 32'(dot), 1);
    check("first_tick_scanline", 32'(scanline), 0);

    // NMI enabled, run into vblank
    wr(3'd0, 8'h80);
    run_to(VBL_POS);
    idle(1'b1);
    check("vbl_nmi_pulse", 32'(nmi_req), 1);
    check("vbl_status", 32'(ppu_status), 32'h80);
    idle(1'b0);
    check("vbl_nmi_one_clk", 32'(nmi_req), 0);
    rd(3'd2);
    check("read1_data", 32'(reg_data_out), 32'h80);
    check("read1_latch_clr", 32'(addr_latch_clr), 1);
    rd(3'd2);
    check("read2_data", 32'(reg_data_out), 32'h00);
    idle(1'b0);
    check("latch_clr_one_clk", 32'(addr_latch_clr), 0);

    // NMI disabled through vblank start, then enabled late
    wr(3'd0, 8'h00);
    run_to(VBL_POS);
    idle(1'b1);
    check("vbl_no_nmi", 32'(nmi_req), 0);
    run_to((VBL + 1) * D + 10);
    wr(3'd0, 8'h80);
    check("late_enable_nmi", 32'(nmi_req), 1);
    idle(1'b0);
    check("late_enable_one_clk", 32'(nmi_req), 0);
    wr(3'd0, 8'h80);
    check("rewrite_no_nmi", 32'(nmi_req), 0);
    idle(1'b0);

    // Status read racing the vblank-set tick
    run_to(VBL_POS);
    step(1'b1, 3'd2, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("race_data", 32'(reg_data_out), 32'h00);
    check("race_no_nmi", 32'(nmi_req), 0);
    idle(1'b0);
    check("race_no_late_nmi", 32'(nmi_req), 0);
    rd(3'd2);
    check("race_vblank_stays0", 32'(reg_data_out), 32'h00);

    // Sprite flags set mid-frame, cleared at pre-render, then frame wrap
    wr(3'd0, 8'h00);
    run_to(5 * D + 3);
    step(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("sprite_flags_set", 32'(ppu_status), 32'h60);
    run_to(PRE_POS);
    check("pre_clear_before", 32'(ppu_status), 32'h60);
    idle(1'b1);
    check("pre_clear_after", 32'(ppu_status), 32'h00);
    run_to(FRAME - 1);
    odd_before = m_odd;
    idle(1'b1);
    check("wrap_dot", 32'(dot), 0);
    check("wrap_scanline", 32'(scanline), 0);
    check("wrap_frame_odd", 32'(frame_odd), 32'(!odd_before));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] a;
      a = ($urandom_range(0, 3) == 3) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      step($urandom_range(0, 3) != 0, a, 8'($urandom),
           $urandom_range(0, 30) == 0, $urandom_range(0, 25) == 0,
           $urandom_range(0, 60) == 0, $urandom_range(0, 60) == 0);
    end
    idle(1'b0);

    // Frame lengths with and without rendering enabled
    frame_lengths(8'h08);
    frame_lengths(8'h00);

    // Asynchronous reset in the middle of a frame and of a read
    wr(3'd0, 8'h80);
    wr(3'd1, 8'h18);
    run_to(VBL_POS);
    idle(1'b1);
    rd(3'd2);
    check("pre_reset_data", 32'(reg_data_out), 32'h80);
    reg_read_en = 1'b1;
    reg_addr = 3'd2;
    #2;
    rst = 1'b1;
    #1;
    check_zero("mid_rst");
    reg_read_en = 1'b0;
    reg_addr = 3'd0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(1'b1);
    check("post_rst_dot", 32'(dot), 1);
    check("post_rst_scanline", 32'(scanline), 0);
    repeat (20) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
